// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers pixel coordinates from a VGA hs/vs/rgb stream, locks to its timing
// and re-emits active pixels with x/y and a data-enable two clocks after the pins.
module vga_sync_rx #(
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int H_DISP      = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int V_DISP      = 480,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic [11:0] vga_rgb,
    output logic [11:0] pix_rgb,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_de,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_err,
    output logic [10:0] h_meas,
    output logic [10:0] v_meas,
    output logic [7:0]  err_cnt
);
    localparam logic [9:0] H_ACT0 = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_ACT1 = 10'(H_SYNC + H_BACK + H_DISP);
    localparam logic [9:0] V_ACT0 = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_ACT1 = 10'(V_SYNC + V_BACK + V_DISP);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [7:0] GOOD_N = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t      state_q, state_d;
    logic        hs_q, vs_q;
    logic [11:0] rgb_q;
    logic [9:0]  pos_h_q, pos_h_d, pos_v_q, pos_v_d;
    logic [10:0] h_meas_q, h_meas_d, v_meas_q, v_meas_d;
    logic [7:0]  good_q, good_d, err_cnt_q, err_cnt_d;
    logic        first_q, first_d, err_d, locked_q, locked_d, sync_err_q;
    logic        pix_de_q, pix_de_d, frame_start_q, frame_start_d;
    logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [11:0] pix_rgb_q, pix_rgb_d;
    logic        hs_fall, vs_fall, h_sat, line_ok, frame_ok;

    assign hs_fall  = hs_q & ~vga_hs;
    assign vs_fall  = vs_q & ~vga_vs;
    assign h_sat    = pos_h_q == 10'h3FF;
    assign line_ok  = pos_h_q == H_LAST;
    assign frame_ok = pos_v_q == V_LAST;

    always_comb begin
        pos_h_d  = hs_fall ? 10'd0 : h_sat ? pos_h_q : pos_h_q + 10'd1;
        pos_v_d  = !hs_fall ? pos_v_q : vs_fall ? 10'd0 : (pos_v_q == 10'h3FF) ? pos_v_q : pos_v_q + 10'd1;
        h_meas_d = hs_fall ? {1'b0, pos_h_q} + 11'd1 : h_meas_q;
        v_meas_d = (hs_fall && vs_fall) ? {1'b0, pos_v_q} + 11'd1 : v_meas_q;
    end

    // The first vsync seen in VERIFY closes a frame that may have started before the search
    // ended, so a bad length there is not held against the link.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        first_d = first_q;
        err_d   = 1'b0;
        case (state_q)
            SEARCH: if (vs_fall) begin
                state_d = VERIFY;
                good_d  = 8'd0;
                first_d = 1'b1;
            end
            VERIFY: if (h_sat || (hs_fall && !line_ok)) state_d = SEARCH;
                else if (vs_fall) begin
                    first_d = 1'b0;
                    if (frame_ok) begin
                        good_d = good_q + 8'd1;
                        if (good_q + 8'd1 == GOOD_N) state_d = LOCKED;
                    end else if (!first_q) state_d = SEARCH;
                end
            LOCKED: if (h_sat || (hs_fall && !line_ok) || (vs_fall && !frame_ok)) begin
                state_d = SEARCH;
                err_d   = 1'b1;
            end
            default: state_d = SEARCH;
        endcase
    end

    always_comb begin
        err_cnt_d     = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
        locked_d      = state_d == LOCKED;
        pix_de_d      = locked_d && pos_h_q >= H_ACT0 && pos_h_q < H_ACT1 && pos_v_q >= V_ACT0 && pos_v_q < V_ACT1;
        pix_x_d       = pix_de_d ? pos_h_q - H_ACT0 : 10'd0;
        pix_y_d       = pix_de_d ? pos_v_q - V_ACT0 : 10'd0;
        pix_rgb_d     = pix_de_d ? rgb_q : 12'd0;
        frame_start_d = pix_de_d && pos_h_q == H_ACT0 && pos_v_q == V_ACT0;
    end

    always_ff @(posedge vga_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            state_q       <= SEARCH;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            rgb_q         <= '0;
            pos_h_q       <= '0;
            pos_v_q       <= '0;
            h_meas_q      <= '0;
            v_meas_q      <= '0;
            good_q        <= '0;
            first_q       <= 1'b0;
            err_cnt_q     <= '0;
            locked_q      <= 1'b0;
            sync_err_q    <= 1'b0;
            pix_de_q      <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_rgb_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs_q          <= vga_hs;
            vs_q          <= vga_vs;
            rgb_q         <= vga_rgb;
            pos_h_q       <= pos_h_d;
            pos_v_q       <= pos_v_d;
            h_meas_q      <= h_meas_d;
            v_meas_q      <= v_meas_d;
            good_q        <= good_d;
            first_q       <= first_d;
            err_cnt_q     <= err_cnt_d;
            locked_q      <= locked_d;
            sync_err_q    <= err_d;
            pix_de_q      <= pix_de_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_rgb_q     <= pix_rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_rgb     = pix_rgb_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_de      = pix_de_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign sync_err    = sync_err_q;
    assign h_meas      = h_meas_q;
    assign v_meas      = v_meas_q;
    assign err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: drives a shrunken VGA-timed stream into vga_sync_rx and checks lock,
// measurement, pixel recovery, error handling and reset behaviour.
module tb_vga_sync_rx;
    localparam int HS = 2, HB = 2, HD = 6, HT = 12;
    localparam int VS = 1, VB = 1, VD = 3, VT = 6;
    localparam int HA0 = HS + HB, HA1 = HA0 + HD, VA0 = VS + VB, VA1 = VA0 + VD;

    logic        vga_clk = 1'b0, sys_rst_n = 1'b1, vga_hs = 1'b1, vga_vs = 1'b1;
    logic [11:0] vga_rgb = '0;
    logic [11:0] pix_rgb;
    logic [9:0]  pix_x, pix_y;
    logic        pix_de, frame_start, locked, sync_err;
    logic [10:0] h_meas, v_meas;
    logic [7:0]  err_cnt;

    vga_sync_rx #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_TOTAL(VT), .LOCK_FRAMES(2)
    ) dut (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_rgb(vga_rgb), .pix_rgb(pix_rgb), .pix_x(pix_x), .pix_y(pix_y),
        .pix_de(pix_de), .frame_start(frame_start), .locked(locked), .sync_err(sync_err),
        .h_meas(h_meas), .v_meas(v_meas), .err_cnt(err_cnt)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        int          l;
        int          c;
        logic        de;
        int          x;
        int          y;
        logic [11:0] rgb;
        logic        fs;
    } vec_t;

    vec_t        tbl [11];
    int          checks = 0, failures = 0;
    int          de_cnt = 0, fs_cnt = 0, err_pulses = 0, err_h = -1, p_l = -1, p_c = -1;
    bit          cap_en = 1'b0;
    logic        cap_de [VT][HT];
    logic        cap_fs [VT][HT];
    logic [9:0]  cap_x  [VT][HT];
    logic [9:0]  cap_y  [VT][HT];
    logic [11:0] cap_rgb[VT][HT];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Outputs read one clock after a sample is applied belong to the sample before it.
    task automatic step(input logic hs, input logic vs, input logic [11:0] rgb, input int l, input int c);
        vga_hs = hs;
        vga_vs = vs;
        vga_rgb = rgb;
        @(posedge vga_clk);
        #1;
        if (cap_en && p_l >= 0 && p_c >= 0 && p_l < VT && p_c < HT) begin
            cap_de[p_l][p_c]  = pix_de;
            cap_fs[p_l][p_c]  = frame_start;
            cap_x[p_l][p_c]   = pix_x;
            cap_y[p_l][p_c]   = pix_y;
            cap_rgb[p_l][p_c] = pix_rgb;
        end
        if (pix_de) de_cnt++;
        if (frame_start) begin
            fs_cnt++;
            chk("fs_pix", {pix_de, pix_x, pix_y, pix_rgb}, {1'b1, 10'd0, 10'd0, 12'd0});
        end
        if (sync_err) begin
            err_pulses++;
            chk("err_unlock", {locked, pix_de}, 2'b00);
            if (err_h >= 0) chk("err_hmeas", h_meas, err_h);
        end
        p_l = l;
        p_c = c;
    endtask

    task automatic px(input int l, input int c);
        logic [11:0] r;
        r = 12'hABC;
        if (l >= VA0 && l < VA1 && c >= HA0 && c < HA1) r = {4'(l - VA0), 8'(c - HA0)};
        step(c >= HS, l >= VS, r, l, c);
    endtask

    task automatic frame(input int bad_l, input int bad_len);
        de_cnt = 0;
        fs_cnt = 0;
        for (int l = 0; l < VT; l++)
            for (int c = 0; c < ((l == bad_l) ? bad_len : HT); c++) px(l, c);
    endtask

    task automatic chk_rst();
        chk("rst_pix", {pix_rgb, pix_x, pix_y, pix_de, frame_start, locked, sync_err}, 64'd0);
        chk("rst_meas", {h_meas, v_meas, err_cnt}, 64'd0);
    endtask

    initial begin
        tbl[0]  = '{2, 4, 1'b1, 0, 0, 12'h000, 1'b1};
        tbl[1]  = '{2, 5, 1'b1, 1, 0, 12'h001, 1'b0};
        tbl[2]  = '{2, 9, 1'b1, 5, 0, 12'h005, 1'b0};
        tbl[3]  = '{2, 10, 1'b0, 0, 0, 12'h000, 1'b0};
        tbl[4]  = '{2, 3, 1'b0, 0, 0, 12'h000, 1'b0};
        tbl[5]  = '{3, 4, 1'b1, 0, 1, 12'h100, 1'b0};
        tbl[6]  = '{4, 9, 1'b1, 5, 2, 12'h205, 1'b0};
        tbl[7]  = '{4, 6, 1'b1, 2, 2, 12'h202, 1'b0};
        tbl[8]  = '{5, 4, 1'b0, 0, 0, 12'h000, 1'b0};
        tbl[9]  = '{1, 6, 1'b0, 0, 0, 12'h000, 1'b0};
        tbl[10] = '{0, 0, 1'b0, 0, 0, 12'h000, 1'b0};

        repeat (3) step(1'b1, 1'b1, 12'h0, -1, -1);
        chk_rst();
        sys_rst_n = 1'b0;

        repeat (3) frame(-1, HT);
        chk("lock_early", locked, 1'b0);
        cap_en = 1'b1;
        frame(-1, HT);
        cap_en = 1'b0;
        chk("lock_nom", locked, 1'b1);
        chk("h_meas", h_meas, HT);
        chk("v_meas", v_meas, VT);
        chk("de_count", de_cnt, HD * VD);
        chk("fs_count", fs_cnt, 1);
        chk("no_err", {err_pulses[7:0], err_cnt}, 16'd0);
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("vec%0d_de", i), cap_de[tbl[i].l][tbl[i].c], tbl[i].de);
            chk($sformatf("vec%0d_x", i), cap_x[tbl[i].l][tbl[i].c], tbl[i].x);
            chk($sformatf("vec%0d_y", i), cap_y[tbl[i].l][tbl[i].c], tbl[i].y);
            chk($sformatf("vec%0d_rgb", i), cap_rgb[tbl[i].l][tbl[i].c], tbl[i].rgb);
            chk($sformatf("vec%0d_fs", i), cap_fs[tbl[i].l][tbl[i].c], tbl[i].fs);
        end

        // one line stretched by a clock while locked
        err_h = HT + 1;
        frame(1, HT + 1);
        err_h = -1;
        chk("stretch_pulses", err_pulses, 1);
        chk("stretch_errcnt", err_cnt, 8'd1);
        chk("stretch_unlock", locked, 1'b0);
        chk("stretch_no_de", de_cnt, 0);
        repeat (2) frame(-1, HT);
        chk("relock_early", locked, 1'b0);
        frame(-1, HT);
        chk("relock", locked, 1'b1);
        chk("relock_de", de_cnt, HD * VD);

        // hsync held high long enough for the column counter to saturate
        err_pulses = 0;
        repeat (1100) step(1'b1, 1'b1, 12'hABC, -1, -1);
        chk("hold_pulses", err_pulses, 1);
        chk("hold_errcnt", err_cnt, 8'd2);
        chk("hold_unlock", locked, 1'b0);
        repeat (2) frame(-1, HT);
        chk("hold_relock_early", locked, 1'b0);
        frame(-1, HT);
        chk("hold_relock", locked, 1'b1);
        chk("hold_no_spurious", err_cnt, 8'd2);
        chk("hold_pulses_after", err_pulses, 1);

        // reset for three clocks spanning the end of a line into the next hsync
        for (int l = 0; l < 3; l++)
            for (int c = 0; c < HT; c++) px(l, c);
        for (int c = 0; c < HT - 2; c++) px(3, c);
        sys_rst_n = 1'b1;
        px(3, HT - 2);
        chk_rst();
        px(3, HT - 1);
        chk_rst();
        px(4, 0);
        chk_rst();
        sys_rst_n = 1'b0;
        for (int c = 1; c < HT; c++) px(4, c);
        px(5, 0);
        chk("no_false_edge", h_meas, HT);
        for (int c = 1; c < HT; c++) px(5, c);
        chk("rst_v_meas", v_meas, 11'd0);
        chk("rst_errcnt", err_cnt, 8'd0);
        repeat (2) frame(-1, HT);
        chk("rst_relock_early", locked, 1'b0);
        frame(-1, HT);
        chk("rst_relock", locked, 1'b1);

        // short first line in each relocked frame to pile up errors
        err_h = HT - 1;
        err_pulses = 0;
        for (int i = 0; i < 257; i++) begin
            frame(0, HT - 1);
            frame(-1, HT);
            frame(-1, HT);
        end
        err_h = -1;
        chk("sat_pulses", err_pulses, 257);
        chk("sat_errcnt", err_cnt, 8'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_sync_rx.md
Name: vga_sync_rx

Overview:
- Receiving end of the 640x480@60 VGA link. Consumes the vga_hs / vga_vs / vga_rgb stream and recovers the horizontal and vertical position of every sample.
- Locks onto the frame timing, checks line and frame lengths against the nominal timing, and re-emits active pixels with x/y coordinates and a data-enable.
- Use: loopback checking of the display path, or capture of a VGA-timed stream.

Parameters:
- H_SYNC 96: hsync low width in clocks.
- H_BACK 48: horizontal back porch.
- H_DISP 640: active pixels per line.
- H_TOTAL 800: clocks per line.
- V_SYNC 2: vsync low width in lines.
- V_BACK 33: vertical back porch.
- V_DISP 480: active lines.
- V_TOTAL 525: lines per frame.
- LOCK_FRAMES 2: consecutive good frames required to lock.

Ports:
- vga_clk  in  1  pixel clock, same as the transmitter clock.
- sys_rst_n  in  1  reset, asynchronous, active-high.
- vga_hs  in  1  hsync, active-low.
- vga_vs  in  1  vsync, active-low.
- vga_rgb  in  12  pixel colour, 4:4:4.
- pix_rgb  out  12  recovered pixel.
- pix_x  out  10  column 0..639.
- pix_y  out  10  row 0..479.
- pix_de  out  1  pix_rgb/pix_x/pix_y valid.
- frame_start  out  1  one-cycle pulse with pixel (0,0).
- locked  out  1  timing lock achieved.
- sync_err  out  1  one-cycle pulse on timing violation while locked.
- h_meas  out  11  last measured line length in clocks.
- v_meas  out  11  last measured frame length in lines.
- err_cnt  out  8  saturating count of sync_err pulses.

Behaviour:
- Reset: all outputs and internal registers go to 0, and the FSM goes to SEARCH. hs_r and vs_r reset to 0, so only a true 1->0 transition after reset counts as an edge.
- Input stage: hs_r, vs_r and rgb_r register the inputs every clock.
- Edge detection, evaluated on the raw inputs against the registers:
  - hs_fall = hs_r & ~vga_hs.
  - vs_fall = vs_r & ~vga_vs.
- Horizontal position pos_h (10 bit):
  - Loads 0 on hs_fall; otherwise increments, saturating at 1023.
  - pos_h always equals the transmitter column index of the sample held in rgb_r.
- Vertical position pos_v (10 bit), updated only on hs_fall:
  - Loads 0 if vs_fall is also true in the same cycle.
  - Otherwise increments, saturating at 1023.
- Measurement:
  - On hs_fall: h_meas <= pos_h+1 (11-bit add, no wrap); line_ok = (pos_h == H_TOTAL-1).
  - On hs_fall & vs_fall: v_meas <= pos_v+1; frame_ok = (pos_v == V_TOTAL-1).
- FSM:
  - SEARCH: on vs_fall go to VERIFY and clear good_cnt.
  - VERIFY: on hs_fall with !line_ok, go to SEARCH. On vs_fall with frame_ok, increment good_cnt; when it reaches LOCK_FRAMES go to LOCKED. On vs_fall with !frame_ok, go to SEARCH.
  - LOCKED: any hs_fall with !line_ok, any vs_fall with !frame_ok, or pos_h reaching 1023 (lost hsync) causes sync_err=1 for one cycle, err_cnt+1 (saturating at 255) and a move to SEARCH.
  - In SEARCH or VERIFY, pos_h saturation forces SEARCH.
- The first frame after entering VERIFY is partial. Its !frame_ok result is ignored: the first vs_fall in VERIFY only starts counting.
- locked = (state == LOCKED), registered.
- Output stage (registered; latency 2 clocks from pins to outputs):
  - pix_de <= locked, and H_SYNC+H_BACK <= pos_h < H_SYNC+H_BACK+H_DISP, and V_SYNC+V_BACK <= pos_v < V_SYNC+V_BACK+V_DISP.
  - When pix_de=1: pix_x <= pos_h-(H_SYNC+H_BACK), pix_y <= pos_v-(V_SYNC+V_BACK), pix_rgb <= rgb_r.
  - When pix_de=0: pix_x, pix_y and pix_rgb are driven to 0.
  - frame_start <= pix_de condition and pos_h == H_SYNC+H_BACK and pos_v == V_SYNC+V_BACK.
- Losing lock clears pix_de on the next clock; no partial-line pixels are emitted after an error.
- Reset mid-frame: the block re-enters SEARCH and needs one vs_fall plus LOCK_FRAMES clean frames before locked rises again.

Test Plan:
- Drive the nominal 800x525 stream (hs low in columns 0..95, vs low in lines 0..1, rgb = {y[3:0],x[7:0]} in the active window) from reset. Required:
  - locked rises within 3 frames.
  - h_meas=800, v_meas=525.
  - Exactly 307200 pix_de per frame.
  - frame_start once per frame, with pix_x=0, pix_y=0, pix_rgb=rgb(0,0).
- Check the 2-cycle latency: the active pixel driven at column 144 appears on pix_* exactly 2 clocks later, with pix_x=0. pix_x=639 is the last pixel with de; pix_de=0 at column 784.
- While locked, stretch one line to 801 clocks. Required: sync_err pulses once, err_cnt=1, locked=0 and pix_de=0 the next clock, h_meas=801, relock after 3 frames.
- Hold hs high for 1100 clocks while locked. Required: sync_err at pos_h saturation, err_cnt increments, and no spurious hs_fall is counted when hs resumes.
- Assert reset mid-line for 3 clocks. Required: all outputs are 0 during reset, and no edge is detected on the first low-hs sample.
- Force 256+ errors. Required: err_cnt saturates at 255.
